ram_reader: RTL

Read initiator for the fixed-latency 256×16 memory block. It accepts a burst command (start address, length), issues single-cycle read requests on the memory's read port, and collects the delayed responses in a local FIFO. It presents them as a valid/ready stream with a last flag. The memory has no backpressure, so issue is gated by credits: a read is only issued when a FIFO slot is already reserved for its response.

---
 rtl/ram_reader_pkg.sv | 23 ++
 rtl/sync_fifo_reg.sv | 58 +++++
 rtl/ram_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ram_reader_pkg.sv
// Shared types and widths for the ram_reader burst read initiator.
// The optional sticky error flag is enabled with RAM_READER_ERR_EN.
package ram_reader_pkg;

  localparam int ADDR_W             = 8;
  localparam int DATA_W             = 16;
  localparam int LEN_W              = 9;
  localparam int RD_LATENCY_DEFAULT = 6;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  // One FIFO entry: the response word tagged with its end-of-burst marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/sync_fifo_reg.sv
// Synchronous FIFO with flop storage, no fall-through and an occupancy count.
// Pushes into a full FIFO are ignored; the caller guarantees space via credits.
module sync_fifo_reg #(
  parameter int  WIDTH = 17,
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstp_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != CNT_W'(DEPTH));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstp_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty-gated read below keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o    = (count_q != '0);
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/ram_reader.sv
// Credit-gated burst reader for the fixed-latency 256x16 memory; responses
// leave through a valid/ready stream. Define RAM_READER_ERR_EN for the err port.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_read,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
`ifdef RAM_READER_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int FLUSH_W = $clog2(RD_LATENCY + 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   rsp_left_q, rsp_left_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [FLUSH_W-1:0] flush_q;
  logic               rd_read_q;
  logic [ADDR_W-1:0]  rd_addr_q;

  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     slots_used;
  logic               fifo_valid;
  logic               has_credit, flushing, rsp_accept, pop, cmd_fire, issue;
  rsp_t               push_word, head_word;

  // Credit is derived from registered values only, so a pop frees a slot next cycle.
  assign slots_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign has_credit = slots_used < (CNT_W + 1)'(FIFO_DEPTH);

  assign flushing   = (flush_q != '0);
  assign rsp_accept = rd_valid && !flushing && (outstanding_q != '0);
  assign cmd_ready  = (state_q == IDLE) && !rstp;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign pop        = fifo_valid && m_ready;

  assign push_word.last = (rsp_left_q == LEN_W'(1));
  assign push_word.data = rd_data;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    rsp_left_d    = rsp_left_q;
    outstanding_d = outstanding_q;
    issue         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire && (cmd_len != '0)) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          rsp_left_d  = cmd_len;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (has_credit) begin
          issue       = 1'b1;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_word.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rsp_accept) rsp_left_d = rsp_left_q - LEN_W'(1);

    if (issue && !rsp_accept)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!issue && rsp_accept) outstanding_d = outstanding_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      rsp_left_q    <= '0;
      outstanding_q <= '0;
      rd_read_q     <= 1'b0;
      rd_addr_q     <= '0;
      flush_q       <= FLUSH_W'(RD_LATENCY);
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      rsp_left_q    <= rsp_left_d;
      outstanding_q <= outstanding_d;
      rd_read_q     <= issue;
      if (issue)    rd_addr_q <= cur_addr_q;
      // Reads launched before reset may still return; ignore them for one latency.
      if (flushing) flush_q   <= flush_q - FLUSH_W'(1);
    end
  end

  sync_fifo_reg #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rstp_i      (rstp),
    .push_i      (rsp_accept),
    .push_data_i (push_word),
    .pop_i       (pop),
    .pop_data_o  (head_word),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign rd_read = rd_read_q;
  assign rd_addr = rd_addr_q;
  assign m_valid = fifo_valid;
  assign m_data  = head_word.data;
  assign m_last  = head_word.last;
  assign busy    = (state_q != IDLE);

`ifdef RAM_READER_ERR_EN
  logic err_q;
  logic fifo_full;

  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rstp) begin
      err_q <= 1'b0;
    end else if ((rd_valid && !flushing && (outstanding_q == '0)) ||
                 (rsp_accept && fifo_full)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule
